serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell, LSB first, WIDTH cycles per result.
// Optional add mode (op_add port) is enabled by defining SERIAL_SUB_ADD_MODE_EN.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op_add,
`endif
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-2:0]   res_q, res_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
  logic               add_q;

  logic               x, y, d, br_next;
  logic [WIDTH-1:0]   res_full;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic add_d;
`else
  assign add_q = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    res_d      = res_q;
    br_d       = br_q;
    cnt_d      = cnt_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
    add_d      = add_q;
`endif

    // Add mode runs the same cell on ~b with an initial borrow of 1: a + b = a - ~b - 1.
    x        = sa_q[0];
    y        = sb_q[0] ^ add_q;
    d        = x ^ y ^ br_q;
    br_next  = (~x & y) | (~(x ^ y) & br_q);
    res_full = {d, res_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = in_a;
          sb_d    = in_b;
          cnt_d   = '0;
          a_msb_d = in_a[WIDTH-1];
          b_msb_d = in_b[WIDTH-1];
`ifdef SERIAL_SUB_ADD_MODE_EN
          add_d   = op_add;
          br_d    = op_add;
`else
          br_d    = 1'b0;
`endif
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = br_next;
        res_d = (WIDTH-1)'(res_full >> 1);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d    = DONE;
          diff_d     = res_full;
          // In add mode the final borrow is the complement of the carry-out.
          borrow_d   = br_next ^ add_q;
          overflow_d = add_q ? ((a_msb_q == b_msb_q) && (d != a_msb_q))
                             : ((a_msb_q != b_msb_q) && (d != a_msb_q));
          zero_d     = (res_full == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      res_q      <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      add_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      res_q      <= res_d;
      br_q       <= br_d;
      cnt_q      <= cnt_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
      add_q      <= add_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a monitor checks each done pulse.
// Add-mode vectors are included only when SERIAL_SUB_ADD_MODE_EN is defined.
module tb_serial_subtractor;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             op_add = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             busy, done, borrow, overflow, zero;
  logic [WIDTH-1:0] diff;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op_add   (op_add),
`endif
    .in_a     (in_a),
    .in_b     (in_b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Wait until the FSM sits in IDLE (neither busy nor done), bounded.
  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((busy || done) && n < 100);
    if (busy || done) timeoutFail("wait_idle");
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk); #1;
      cycles++;
    end while (!done && cycles < 100);
    if (!done) timeoutFail("wait_done");
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic add,
                               input logic [31:0] e_diff, input logic e_borrow,
                               input logic e_ovf, input logic e_zero);
    exp_t e;
    waitIdle();
    e.diff = e_diff; e.borrow = e_borrow; e.overflow = e_ovf; e.zero = e_zero;
    sb.push_back(e);
    in_a   = a;
    in_b   = b;
    op_add = add;
    start  = 1'b1;
    @(negedge clk); #1;
    start  = 1'b0;
    in_a   = $urandom;
    in_b   = $urandom;
  endtask

  // Monitor: every done pulse pops one expectation; busy must have lasted WIDTH cycles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          checkOutput("busy_during_done", 32'(busy), 32'd0);
          checkOutput("busy_cycles", busy_cnt, WIDTH);
          busy_cnt = 0;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: diff 0x%08h with empty scoreboard at %0t", diff, $time);
          end else begin
            e = sb.pop_front();
            checkOutput("diff", diff, e.diff);
            checkOutput("borrow", 32'(borrow), 32'(e.borrow));
            checkOutput("overflow", 32'(overflow), 32'(e.overflow));
            checkOutput("zero", 32'(zero), 32'(e.zero));
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_diff", diff, 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;

    $display("[TB] basic subtract vectors");
    applyStimulus(32'd10, 32'd3, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'd3, 32'd10, 1'b0, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);

    $display("[TB] start pulse during RUN is ignored");
    applyStimulus(32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    in_a = 32'd100; in_b = 32'd1; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;

    $display("[TB] start held high");
    waitIdle();
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.diff = 32'h8000_0000; e.borrow = 1'b1; e.overflow = 1'b1; e.zero = 1'b0;
      sb.push_back(e);
    end
    in_a = 32'h7FFF_FFFF; in_b = 32'hFFFF_FFFF; start = 1'b1;
    waitDone(cyc);
    waitDone(cyc);
    checkOutput("held_gap_1", cyc, 32'd34);
    waitDone(cyc);
    checkOutput("held_gap_2", cyc, 32'd34);
    start = 1'b0;

    $display("[TB] reset during RUN");
    applyStimulus(32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrun_busy", 32'(busy), 32'd0);
    checkOutput("midrun_done", 32'(done), 32'd0);
    checkOutput("midrun_diff", diff, 32'd0);
    checkOutput("midrun_borrow", 32'(borrow), 32'd0);
    checkOutput("midrun_overflow", 32'(overflow), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_SUB_ADD_MODE_EN
    $display("[TB] add mode");
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h4000_0000, 32'h4000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'd10, 32'd3, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);
`endif

    waitIdle();
    waitIdle();
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
